// File: rtl/mc_controller_if.sv
// Control bus between the multi-cycle MIPS controller and its datapath.
// The controller takes the master modport; the datapath (or a bench) takes the slave modport.
interface mc_controller_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             ALUzero;
  logic             IRWE;
  logic             PCWE;
  logic [1:0]       WACtrl;
  logic [1:0]       WDCtrl;
  logic [1:0]       ALUCtrl;
  logic             ALUBCtrl;
  logic             EXTCtrl;
  logic [1:0]       JumpCtrl;
  logic             DM_WE;
  logic             DM_RE;
  logic             GRFWE;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, funct, ALUzero,
    output IRWE, PCWE, WACtrl, WDCtrl, ALUCtrl, ALUBCtrl, EXTCtrl, JumpCtrl,
    output DM_WE, DM_RE, GRFWE, illegal, retired
  );

  modport slave (
    output opcode, funct, ALUzero,
    input  IRWE, PCWE, WACtrl, WDCtrl, ALUCtrl, ALUBCtrl, EXTCtrl, JumpCtrl,
    input  DM_WE, DM_RE, GRFWE, illegal, retired
  );
endinterface

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath
// controls and PC/IR write enables, and counts retired instructions.
module mc_controller #(
  parameter int unsigned DM_LAT = 1,
  parameter int unsigned CNT_W  = 32
) (
  input logic            clk,
  input logic            reset,
  mc_controller_if.master bus
);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb} state_e;
  typedef enum logic [3:0] {
    InAddu, InSubu, InOri, InLui, InLw, InSw, InBeq, InJ, InJr, InJal, InIll
  } instr_e;

  localparam logic [3:0] MemLoad = 4'(DM_LAT - 1);

  state_e           state_q, state_d;
  logic [3:0]       mem_cnt_q, mem_cnt_d;
  logic [CNT_W-1:0] retired_q;
  instr_e           instr;
  logic             last_cycle;

  always_comb begin
    instr = InIll;
    case (bus.opcode)
      6'h00: begin
        case (bus.funct)
          6'h21:   instr = InAddu;
          6'h23:   instr = InSubu;
          6'h08:   instr = InJr;
          default: instr = InIll;
        endcase
      end
      6'h0D:   instr = InOri;
      6'h0F:   instr = InLui;
      6'h23:   instr = InLw;
      6'h2B:   instr = InSw;
      6'h04:   instr = InBeq;
      6'h02:   instr = InJ;
      6'h03:   instr = InJal;
      default: instr = InIll;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mem_cnt_d = mem_cnt_q;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        if (instr == InJ || instr == InJr || instr == InJal || instr == InIll) begin
          state_d = StFetch;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (instr == InBeq) begin
          state_d = StFetch;
        end else if (instr == InLw || instr == InSw) begin
          state_d   = StMem;
          mem_cnt_d = MemLoad;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (mem_cnt_q == 4'd0) begin
          state_d = (instr == InLw) ? StWb : StFetch;
        end else begin
          mem_cnt_d = mem_cnt_q - 4'd1;
        end
      end
      StWb:    state_d = StFetch;
      default: state_d = StFetch;
    endcase
  end

  // Leaving any non-FETCH state back to FETCH marks the instruction's final cycle.
  assign last_cycle = (state_q != StFetch) && (state_d == StFetch);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StFetch;
      mem_cnt_q <= 4'd0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      mem_cnt_q <= mem_cnt_d;
      if (last_cycle) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    bus.IRWE     = 1'b0;
    bus.PCWE     = 1'b0;
    bus.WACtrl   = 2'b00;
    bus.WDCtrl   = 2'b00;
    bus.ALUCtrl  = 2'b00;
    bus.ALUBCtrl = 1'b0;
    bus.EXTCtrl  = 1'b0;
    bus.JumpCtrl = 2'b00;
    bus.DM_WE    = 1'b0;
    bus.DM_RE    = 1'b0;
    bus.GRFWE    = 1'b0;
    bus.illegal  = 1'b0;
    // Outputs are forced low while reset is held so no write can leak through.
    if (reset) begin
      if (state_q == StFetch) begin
        bus.IRWE = 1'b1;
      end else begin
        bus.PCWE = last_cycle;
        case (instr)
          InAddu: bus.WACtrl = 2'b01;
          InSubu: begin
            bus.WACtrl  = 2'b01;
            bus.ALUCtrl = 2'b01;
          end
          InOri: begin
            bus.ALUCtrl  = 2'b10;
            bus.ALUBCtrl = 1'b1;
          end
          InLui: begin
            bus.ALUCtrl  = 2'b11;
            bus.ALUBCtrl = 1'b1;
          end
          InLw: begin
            bus.ALUBCtrl = 1'b1;
            bus.EXTCtrl  = 1'b1;
            bus.WDCtrl   = 2'b01;
            bus.DM_RE    = (state_q == StMem);
          end
          InSw: begin
            bus.ALUBCtrl = 1'b1;
            bus.EXTCtrl  = 1'b1;
            bus.DM_WE    = (state_q == StMem) && (mem_cnt_q == MemLoad);
          end
          InBeq: begin
            bus.ALUCtrl  = 2'b01;
            bus.JumpCtrl = bus.ALUzero ? 2'b01 : 2'b00;
          end
          InJ:  bus.JumpCtrl = 2'b10;
          InJr: bus.JumpCtrl = 2'b11;
          InJal: begin
            bus.WACtrl   = 2'b10;
            bus.WDCtrl   = 2'b10;
            bus.JumpCtrl = 2'b10;
          end
          default: bus.illegal = (state_q == StDecode);
        endcase
        bus.GRFWE = (state_q == StWb) || (state_q == StDecode && instr == InJal);
      end
    end
  end

  assign bus.retired = retired_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: three instances (DM_LAT 3/2/1, one with a 4-bit counter) run a
// directed program against an instruction-level model; literal checks pin key cycles.
module tb_mc_controller;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mc_controller_if #(.CNT_W(32)) if_a ();
  mc_controller_if #(.CNT_W(32)) if_b ();
  mc_controller_if #(.CNT_W(4))  if_c ();

  mc_controller #(.DM_LAT(3), .CNT_W(32)) u_a (.clk(clk), .reset(reset), .bus(if_a));
  mc_controller #(.DM_LAT(2), .CNT_W(32)) u_b (.clk(clk), .reset(reset), .bus(if_b));
  mc_controller #(.DM_LAT(1), .CNT_W(4))  u_c (.clk(clk), .reset(reset), .bus(if_c));

  typedef struct packed {
    logic       irwe;
    logic       pcwe;
    logic [1:0] wa;
    logic [1:0] wd;
    logic [1:0] alu;
    logic       alub;
    logic       ext;
    logic [1:0] jmp;
    logic       dm_we;
    logic       dm_re;
    logic       grfwe;
    logic       illegal;
  } out_t;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
  } ins_t;

  localparam int NProg = 13;

  ins_t        prog [NProg];
  ins_t        lw_ins;
  int          k [3];
  int          ip [3];
  longint      ret [3];
  bit          in_rst;
  bit          lw_only;
  bit          checking;
  int          cyc;
  int          total;
  int          bad;
  out_t        act [3];
  logic [31:0] act_ret [3];
  out_t        hist [3][64];
  longint      hist_ret [3][64];

  assign act[0] = {if_a.IRWE, if_a.PCWE, if_a.WACtrl, if_a.WDCtrl, if_a.ALUCtrl, if_a.ALUBCtrl,
                   if_a.EXTCtrl, if_a.JumpCtrl, if_a.DM_WE, if_a.DM_RE, if_a.GRFWE, if_a.illegal};
  assign act[1] = {if_b.IRWE, if_b.PCWE, if_b.WACtrl, if_b.WDCtrl, if_b.ALUCtrl, if_b.ALUBCtrl,
                   if_b.EXTCtrl, if_b.JumpCtrl, if_b.DM_WE, if_b.DM_RE, if_b.GRFWE, if_b.illegal};
  assign act[2] = {if_c.IRWE, if_c.PCWE, if_c.WACtrl, if_c.WDCtrl, if_c.ALUCtrl, if_c.ALUBCtrl,
                   if_c.EXTCtrl, if_c.JumpCtrl, if_c.DM_WE, if_c.DM_RE, if_c.GRFWE, if_c.illegal};
  assign act_ret[0] = if_a.retired;
  assign act_ret[1] = if_b.retired;
  assign act_ret[2] = {28'd0, if_c.retired};

  function automatic int lat_of(input int i);
    return (i == 0) ? 3 : (i == 1) ? 2 : 1;
  endfunction

  function automatic longint mask_of(input int i);
    return (i == 2) ? 64'hF : 64'hFFFF_FFFF;
  endfunction

  function automatic ins_t cur_ins(input int i);
    return lw_only ? lw_ins : prog[ip[i]];
  endfunction

  // Instruction kinds: 0 addu 1 subu 2 ori 3 lui 4 lw 5 sw 6 beq 7 j 8 jr 9 jal 10 illegal
  function automatic int kind_of(input ins_t c);
    case (c.op)
      6'h00:   return (c.fn == 6'h21) ? 0 : (c.fn == 6'h23) ? 1 : (c.fn == 6'h08) ? 8 : 10;
      6'h0D:   return 2;
      6'h0F:   return 3;
      6'h23:   return 4;
      6'h2B:   return 5;
      6'h04:   return 6;
      6'h02:   return 7;
      6'h03:   return 9;
      default: return 10;
    endcase
  endfunction

  function automatic int len_of(input ins_t c, input int lat);
    case (kind_of(c))
      0, 1, 2, 3: return 4;
      4:          return 4 + lat;
      5:          return 3 + lat;
      6:          return 3;
      default:    return 2;
    endcase
  endfunction

  function automatic out_t model_out(input ins_t c, input int lat, input int kk);
    out_t o;
    int   len;
    o = '0;
    len = len_of(c, lat);
    if (kk == 0) begin
      o.irwe = 1'b1;
      return o;
    end
    o.pcwe = (kk == len - 1);
    case (kind_of(c))
      0: begin o.wa = 2'd1; o.grfwe = (kk == 3); end
      1: begin o.wa = 2'd1; o.alu = 2'd1; o.grfwe = (kk == 3); end
      2: begin o.alu = 2'd2; o.alub = 1'b1; o.grfwe = (kk == 3); end
      3: begin o.alu = 2'd3; o.alub = 1'b1; o.grfwe = (kk == 3); end
      4: begin
        o.alub = 1'b1; o.ext = 1'b1; o.wd = 2'd1;
        o.dm_re = (kk >= 3) && (kk < 3 + lat);
        o.grfwe = (kk == 3 + lat);
      end
      5: begin o.alub = 1'b1; o.ext = 1'b1; o.dm_we = (kk == 3); end
      6: begin o.alu = 2'd1; o.jmp = c.z ? 2'd1 : 2'd0; end
      7: o.jmp = 2'd2;
      8: o.jmp = 2'd3;
      9: begin o.wa = 2'd2; o.wd = 2'd2; o.jmp = 2'd2; o.grfwe = (kk == 1); end
      default: o.illegal = (kk == 1);
    endcase
    return o;
  endfunction

  task automatic chk(input string name, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic drive();
    ins_t c;
    c = cur_ins(0);
    if_a.opcode = c.op; if_a.funct = c.fn; if_a.ALUzero = c.z;
    c = cur_ins(1);
    if_b.opcode = c.op; if_b.funct = c.fn; if_b.ALUzero = c.z;
    c = cur_ins(2);
    if_c.opcode = c.op; if_c.funct = c.fn; if_c.ALUzero = c.z;
  endtask

  task automatic advance();
    for (int i = 0; i < 3; i++) begin
      if (k[i] == len_of(cur_ins(i), lat_of(i)) - 1) begin
        k[i]   = 0;
        ret[i] = ret[i] + 1;
        ip[i]  = (ip[i] + 1) % NProg;
      end else begin
        k[i] = k[i] + 1;
      end
    end
    cyc++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      k[i]   = 0;
      ip[i]  = 0;
      ret[i] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 3; i++) begin
        out_t   exp_o;
        longint exp_r;
        exp_o = in_rst ? out_t'('0) : model_out(cur_ins(i), lat_of(i), k[i]);
        exp_r = in_rst ? 64'd0 : (ret[i] & mask_of(i));
        chk($sformatf("u%0d_ctrl_cyc%0d", i, cyc), longint'(act[i]), longint'(exp_o));
        chk($sformatf("u%0d_retired_cyc%0d", i, cyc), longint'(act_ret[i]), exp_r);
        if (!in_rst && cyc < 64) begin
          hist[i][cyc]     = act[i];
          hist_ret[i][cyc] = longint'(act_ret[i]);
        end
      end
    end
  end

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    checking = 1'b0;
    lw_only = 1'b0;
    in_rst = 1'b1;
    prog[0]  = '{op: 6'h00, fn: 6'h21, z: 1'b1};  // addu
    prog[1]  = '{op: 6'h00, fn: 6'h23, z: 1'b0};  // subu
    prog[2]  = '{op: 6'h0D, fn: 6'h21, z: 1'b1};  // ori
    prog[3]  = '{op: 6'h0F, fn: 6'h00, z: 1'b0};  // lui
    prog[4]  = '{op: 6'h23, fn: 6'h00, z: 1'b1};  // lw
    prog[5]  = '{op: 6'h2B, fn: 6'h00, z: 1'b0};  // sw
    prog[6]  = '{op: 6'h04, fn: 6'h00, z: 1'b1};  // beq taken
    prog[7]  = '{op: 6'h04, fn: 6'h00, z: 1'b0};  // beq not taken
    prog[8]  = '{op: 6'h03, fn: 6'h00, z: 1'b0};  // jal
    prog[9]  = '{op: 6'h02, fn: 6'h00, z: 1'b1};  // j
    prog[10] = '{op: 6'h00, fn: 6'h08, z: 1'b0};  // jr
    prog[11] = '{op: 6'h3F, fn: 6'h00, z: 1'b0};  // undefined opcode
    prog[12] = '{op: 6'h00, fn: 6'h3F, z: 1'b1};  // undefined funct
    lw_ins   = '{op: 6'h23, fn: 6'h00, z: 1'b0};
    model_reset();
    drive();
    checking = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    in_rst = 1'b0;
    cyc = 0;
    repeat (60) begin
      @(posedge clk);
      advance();
      #1 drive();
    end

    // Reset in the middle of an lw MEM phase.
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_rst = 1'b1;
    lw_only = 1'b1;
    model_reset();
    drive();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    in_rst = 1'b0;
    for (int n = 0; n < 20 && k[0] != 4; n++) begin
      @(posedge clk);
      advance();
      #1 drive();
    end
    chk("reached_lw_mem", k[0], 4);
    @(negedge clk);
    #1;
    chk("pre_reset_dm_re", if_a.DM_RE, 1);
    reset = 1'b0;
    in_rst = 1'b1;
    model_reset();
    #1;
    chk("in_reset_dm_re", if_a.DM_RE, 0);
    chk("in_reset_irwe", if_a.IRWE, 0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    in_rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_reset_irwe", if_a.IRWE, 1);
    chk("post_reset_grfwe", if_a.GRFWE, 0);
    chk("post_reset_retired", longint'(if_a.retired), 0);
    repeat (10) begin
      @(posedge clk);
      advance();
      #1 drive();
    end
    @(negedge clk);
    checking = 1'b0;

    // Hand-computed cycle expectations for the first program pass.
    chk("addu_irwe_c0", hist[0][0].irwe, 1);
    chk("addu_grfwe_c3", hist[0][3].grfwe, 1);
    chk("addu_wa_c3", hist[0][3].wa, 1);
    chk("addu_pcwe_c3", hist[0][3].pcwe, 1);
    chk("addu_retired_c4", hist_ret[0][4], 1);
    chk("lw3_dm_re_c18", hist[0][18].dm_re, 0);
    for (int c = 19; c <= 21; c++) chk($sformatf("lw3_dm_re_c%0d", c), hist[0][c].dm_re, 1);
    chk("lw3_grfwe_c22", hist[0][22].grfwe, 1);
    chk("lw3_wd_c22", hist[0][22].wd, 1);
    chk("lw3_next_irwe_c23", hist[0][23].irwe, 1);
    chk("sw2_dm_we_c25", hist[1][25].dm_we, 1);
    chk("sw2_dm_we_c26", hist[1][26].dm_we, 0);
    chk("sw2_pcwe_c26", hist[1][26].pcwe, 1);
    for (int c = 22; c <= 26; c++) chk($sformatf("sw2_grfwe_c%0d", c), hist[1][c].grfwe, 0);
    chk("beq_taken_jmp", hist[0][31].jmp, 1);
    chk("beq_taken_pcwe", hist[0][31].pcwe, 1);
    chk("beq_not_taken_jmp", hist[0][34].jmp, 0);
    chk("beq_not_taken_pcwe", hist[0][34].pcwe, 1);
    chk("jal_grfwe", hist[0][36].grfwe, 1);
    chk("jal_wa", hist[0][36].wa, 2);
    chk("jal_wd", hist[0][36].wd, 2);
    chk("jal_jmp", hist[0][36].jmp, 2);
    chk("jal_pcwe", hist[0][36].pcwe, 1);
    chk("ill_pulse_c42", hist[0][42].illegal, 1);
    chk("ill_pcwe_c42", hist[0][42].pcwe, 1);
    chk("ill_pulse_c43", hist[0][43].illegal, 0);
    chk("wrap_before", hist_ret[2][52], 15);
    chk("wrap_after", hist_ret[2][53], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
